// File: rtl/memory_arbiter_pkg.sv
// Shared types for the miss-path memory arbiter: the cache request record,
// the arbiter FSM states and the requester ids.
package memory_arbiter_pkg;

  localparam int DCACHE_LINE_WIDTH = 128;
  localparam int ADDR_W            = 32;
  localparam int MEM_LATENCY_DEF   = 10;
  localparam int MEM_DEPTH_DEF     = 4096;
  localparam int LINE_BYTES_DEF    = DCACHE_LINE_WIDTH / 8;

  typedef struct packed {
    logic [ADDR_W-1:0]            addr;
    logic                         is_store;
    logic [DCACHE_LINE_WIDTH-1:0] data;
  } memory_request_t;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} arb_state_t;

  typedef enum logic {ICACHE = 1'b0, DCACHE = 1'b1} port_id_t;

endpackage

// File: rtl/memory_arbiter_main_memory.sv
// Single-port line-wide synchronous RAM: one access per enabled cycle,
// read data registered and available the following cycle.
module main_memory #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 128
) (
  input  logic                     clock,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter between icache and dcache miss ports in front of a
// fixed-latency main memory; one transaction in flight at a time.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int MEM_LATENCY = MEM_LATENCY_DEF,
  parameter int MEM_DEPTH   = MEM_DEPTH_DEF,
  parameter int LINE_BYTES  = LINE_BYTES_DEF
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         icache_req_valid,
  input  memory_request_t              icache_req_info,
  output logic                         icache_rsp_valid,
  output logic [DCACHE_LINE_WIDTH-1:0] icache_rsp_data,
  input  logic                         dcache_req_valid,
  input  memory_request_t              dcache_req_info,
  output logic                         dcache_rsp_valid,
  output logic [DCACHE_LINE_WIDTH-1:0] dcache_rsp_data
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int CNT_W = $clog2(MEM_LATENCY);

  arb_state_t                   state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  memory_request_t              req_q, req_d;
  port_id_t                     port_q, port_d;
  port_id_t                     last_q, last_d;
  logic                         mask_q, mask_d;
  logic [DCACHE_LINE_WIDTH-1:0] i_data_q, i_data_d;
  logic [DCACHE_LINE_WIDTH-1:0] d_data_q, d_data_d;

  logic                         i_ok, d_ok, mem_en;
  port_id_t                     grant;
  logic [DCACHE_LINE_WIDTH-1:0] mem_rdata, resp_line;
  logic                         unused_addr;

  // Upper address bits alias onto the same lines; they are intentionally dropped.
  assign unused_addr = ^req_q.addr;

  main_memory #(.DEPTH(MEM_DEPTH), .WIDTH(DCACHE_LINE_WIDTH)) u_mem (
    .clock (clock),
    .en    (mem_en && !reset),
    .we    (req_q.is_store),
    .addr  (req_q.addr[OFF_W +: IDX_W]),
    .wdata (req_q.data),
    .rdata (mem_rdata)
  );

  // A store acknowledges with the line it wrote rather than a RAM read-back.
  assign resp_line = req_q.is_store ? req_q.data : mem_rdata;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    port_d   = port_q;
    last_d   = last_q;
    mask_d   = 1'b0;
    i_data_d = i_data_q;
    d_data_d = d_data_q;
    mem_en   = 1'b0;
    // The port just served may still show valid for one cycle after its response.
    i_ok  = icache_req_valid && !(mask_q && port_q == ICACHE);
    d_ok  = dcache_req_valid && !(mask_q && port_q == DCACHE);
    grant = ICACHE;
    if (i_ok && d_ok) grant = (last_q == ICACHE) ? DCACHE : ICACHE;
    else if (d_ok)    grant = DCACHE;
    case (state_q)
      IDLE: if (i_ok || d_ok) begin
        state_d = WAIT;
        cnt_d   = CNT_W'(MEM_LATENCY - 2);
        port_d  = grant;
        last_d  = grant;
        req_d   = (grant == DCACHE) ? dcache_req_info : icache_req_info;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          mem_en  = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        mask_d  = 1'b1;
        if (port_q == ICACHE) i_data_d = resp_line;
        else                  d_data_d = resp_line;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      req_q    <= '0;
      port_q   <= ICACHE;
      last_q   <= ICACHE;
      mask_q   <= 1'b0;
      i_data_q <= '0;
      d_data_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      port_q   <= port_d;
      last_q   <= last_d;
      mask_q   <= mask_d;
      i_data_q <= i_data_d;
      d_data_q <= d_data_d;
    end
  end

  assign icache_rsp_valid = (state_q == RESP) && (port_q == ICACHE);
  assign dcache_rsp_valid = (state_q == RESP) && (port_q == DCACHE);
  assign icache_rsp_data  = icache_rsp_valid ? resp_line : i_data_q;
  assign dcache_rsp_data  = dcache_rsp_valid ? resp_line : d_data_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: single-port vector table plus hand
// sequences for contention, round-robin order and mid-transaction reset.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  logic                         clock = 1'b0;
  logic                         reset = 1'b1;
  logic                         icache_req_valid = 1'b0;
  memory_request_t              icache_req_info  = '0;
  logic                         icache_rsp_valid;
  logic [DCACHE_LINE_WIDTH-1:0] icache_rsp_data;
  logic                         dcache_req_valid = 1'b0;
  memory_request_t              dcache_req_info  = '0;
  logic                         dcache_rsp_valid;
  logic [DCACHE_LINE_WIDTH-1:0] dcache_rsp_data;

  memory_arbiter #(.MEM_LATENCY(10), .MEM_DEPTH(4096), .LINE_BYTES(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .icache_req_valid (icache_req_valid),
    .icache_req_info  (icache_req_info),
    .icache_rsp_valid (icache_rsp_valid),
    .icache_rsp_data  (icache_rsp_data),
    .dcache_req_valid (dcache_req_valid),
    .dcache_req_info  (dcache_req_info),
    .dcache_rsp_valid (dcache_rsp_valid),
    .dcache_rsp_data  (dcache_rsp_data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int i_cnt = 0, d_cnt = 0, both_hi = 0;
  int tests = 0, fails = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (icache_rsp_valid && dcache_rsp_valid) both_hi++;
    if (icache_rsp_valid) i_cnt++;
    if (dcache_rsp_valid) d_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    bit          is_d;
    logic [31:0] addr;
    bit          st;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  localparam logic [127:0] LA = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] LB = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
  localparam logic [127:0] LC = 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF;
  localparam logic [127:0] LE = 128'hEEEE0000111122223333444455556666;
  localparam logic [127:0] LF = 128'hFFFF9999888877776666555544443333;
  localparam logic [127:0] LP = 128'h50505050A0A0A0A050505050A0A0A0A0;
  localparam logic [127:0] LQ = 128'h0000000011111111222222223333333F;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic set_port(input bit is_d, input bit v, input memory_request_t r);
    if (is_d) begin dcache_req_valid = v; dcache_req_info = r; end
    else      begin icache_req_valid = v; icache_req_info = r; end
  endtask

  function automatic memory_request_t mkreq(input logic [31:0] a, input bit st, input logic [127:0] d);
    memory_request_t r;
    r.addr = a; r.is_store = st; r.data = d;
    return r;
  endfunction

  // One transaction on one port; info is scrambled after the grant cycle.
  task automatic run(input vec_t v, output logic [127:0] got, output int lat,
                     output int own_n, output int other_n);
    int i0, d0, start;
    memory_request_t r;
    @(negedge clock); #1;
    i0 = i_cnt; d0 = d_cnt;
    r = mkreq(v.addr, v.st, v.data);
    set_port(v.is_d, 1'b1, r);
    start = cyc;
    lat = -1; got = '0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clock);
      if (n == 1) set_port(v.is_d, 1'b1, mkreq(v.addr ^ 32'h5A0, ~v.st, ~v.data));
      if (v.is_d ? dcache_rsp_valid : icache_rsp_valid) begin
        lat = cyc - start;
        got = v.is_d ? dcache_rsp_data : icache_rsp_data;
        break;
      end
    end
    @(negedge clock);
    set_port(v.is_d, 1'b0, r);
    #1;
    own_n   = v.is_d ? d_cnt - d0 : i_cnt - i0;
    other_n = v.is_d ? i_cnt - i0 : d_cnt - d0;
  endtask

  // Two back-to-back requests, valid held one cycle past each response.
  task automatic drv2(input bit is_d, input memory_request_t r0, input memory_request_t r1,
                      output int c0, output int c1, output logic [127:0] g0, output logic [127:0] g1);
    c0 = -1; c1 = -1; g0 = '0; g1 = '0;
    for (int k = 0; k < 2; k++) begin
      set_port(is_d, 1'b1, (k == 0) ? r0 : r1);
      for (int n = 0; n < 60; n++) begin
        @(negedge clock);
        if (is_d ? dcache_rsp_valid : icache_rsp_valid) begin
          if (k == 0) begin c0 = cyc; g0 = is_d ? dcache_rsp_data : icache_rsp_data; end
          else        begin c1 = cyc; g1 = is_d ? dcache_rsp_data : icache_rsp_data; end
          break;
        end
      end
      @(negedge clock);
      set_port(is_d, 1'b0, (k == 0) ? r0 : r1);
      @(negedge clock);
    end
  endtask

  vec_t tbl [8];
  logic [127:0] got, dg0, dg1, ig0, ig1;
  int lat, own_n, other_n, s, dc0, dc1, ic0, ic1, i0, d0, both0;

  initial begin
    tbl[0] = '{1'b1, 32'h100,   1'b1, LA, LA};
    tbl[1] = '{1'b1, 32'h100,   1'b0, '0, LA};
    tbl[2] = '{1'b1, 32'h200,   1'b1, LB, LB};
    tbl[3] = '{1'b0, 32'h200,   1'b0, '0, LB};
    tbl[4] = '{1'b1, 32'h10,    1'b1, LC, LC};
    tbl[5] = '{1'b0, 32'h10010, 1'b0, '0, LC};
    tbl[6] = '{1'b1, 32'h300,   1'b1, LE, LE};
    tbl[7] = '{1'b0, 32'h104,   1'b0, '0, LA};

    repeat (3) @(negedge clock);
    chk("rst_i_valid", 128'(icache_rsp_valid), 128'(0));
    chk("rst_d_valid", 128'(dcache_rsp_valid), 128'(0));
    chk("rst_i_data",  icache_rsp_data, '0);
    chk("rst_d_data",  dcache_rsp_data, '0);
    chk("rst_state",   128'(dut.state_q), 128'(IDLE));

    // Contention straight out of reset: expect order D,I,D,I.
    reset = 1'b0;
    s = cyc;
    both0 = both_hi;
    i0 = i_cnt; d0 = d_cnt;
    fork
      drv2(1'b1, mkreq(32'h400, 1'b1, LP), mkreq(32'h500, 1'b1, LQ), dc0, dc1, dg0, dg1);
      drv2(1'b0, mkreq(32'h400, 1'b0, '0), mkreq(32'h500, 1'b0, '0), ic0, ic1, ig0, ig1);
    join
    repeat (3) @(negedge clock); #1;
    chk("rr_d0_cycle", 128'(dc0 - s), 128'(10));
    chk("rr_i0_cycle", 128'(ic0 - s), 128'(21));
    chk("rr_d1_cycle", 128'(dc1 - s), 128'(32));
    chk("rr_i1_cycle", 128'(ic1 - s), 128'(43));
    chk("rr_d0_data", dg0, LP);
    chk("rr_i0_data", ig0, LP);
    chk("rr_i1_data", ig1, LQ);
    chk("rr_both_hi", 128'(both_hi - both0), 128'(0));
    chk("rr_d_count", 128'(d_cnt - d0), 128'(2));
    chk("rr_i_count", 128'(i_cnt - i0), 128'(2));

    for (int k = 0; k < 8; k++) begin
      run(tbl[k], got, lat, own_n, other_n);
      chk($sformatf("vec%0d_data", k), got, tbl[k].exp);
      chk($sformatf("vec%0d_latency", k), 128'(lat), 128'(10));
      chk($sformatf("vec%0d_own_rsp", k), 128'(own_n), 128'(1));
      chk($sformatf("vec%0d_other_rsp", k), 128'(other_n), 128'(0));
    end

    // Reset at g+5 of a store to 0x300 must drop it entirely.
    @(negedge clock); #1;
    i0 = i_cnt; d0 = d_cnt;
    set_port(1'b1, 1'b1, mkreq(32'h300, 1'b1, LF));
    repeat (5) @(negedge clock);
    reset = 1'b1;
    set_port(1'b1, 1'b0, mkreq(32'h300, 1'b1, LF));
    @(negedge clock);
    reset = 1'b0;
    repeat (10) @(negedge clock); #1;
    chk("rst_mid_d_rsp", 128'(d_cnt - d0), 128'(0));
    chk("rst_mid_i_rsp", 128'(i_cnt - i0), 128'(0));
    chk("rst_mid_state", 128'(dut.state_q), 128'(IDLE));
    run('{1'b0, 32'h300, 1'b0, '0, LE}, got, lat, own_n, other_n);
    chk("rst_mid_line", got, LE);
    chk("rst_mid_latency", 128'(lat), 128'(10));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
